// File: rtl/dma_ctrl_pkg.sv
// Shared types and constants for the single-channel word-copy DMA engine.
// Bus strobes are active low; READ/WRITE follow the chip bus encoding.
package dma_ctrl_pkg;

  localparam int CNT_W       = 16;
  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int DMA_ADDR_W  = 2;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int CTRL_BUSY = 0;
  localparam int CTRL_DONE = 1;
  localparam int CTRL_IE   = 2;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_SRC   = 2'd1,
    REG_DST   = 2'd2,
    REG_COUNT = 2'd3
  } dma_reg_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RD_AS   = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_WR_AS   = 3'd4,
    ST_WR_WAIT = 3'd5,
    ST_NEXT    = 3'd6
  } dma_state_e;

  // Word addresses wrap modulo 2^WORD_ADDR_W.
  function automatic logic [WORD_ADDR_W-1:0] word_inc(input logic [WORD_ADDR_W-1:0] a);
    return a + 30'd1;
  endfunction

endpackage

// File: rtl/dma_ctrl_if.sv
// Chip-bus connection of the DMA: slave register port (s5) and master port (m2).
// Both modports are seen from the DMA side.
interface dma_ctrl_if;
  import dma_ctrl_pkg::*;

  logic                   cs_;
  logic                   as_;
  logic                   rw;
  logic [DMA_ADDR_W-1:0]  addr;
  logic [WORD_DATA_W-1:0] wr_data;
  logic [WORD_DATA_W-1:0] rd_data;
  logic                   rdy_;

  logic                   m_req_;
  logic                   m_grnt_;
  logic [WORD_ADDR_W-1:0] m_addr;
  logic                   m_as_;
  logic                   m_rw;
  logic [WORD_DATA_W-1:0] m_wr_data;
  logic [WORD_DATA_W-1:0] m_rd_data;
  logic                   m_rdy_;

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );

  modport master (
    output m_req_, m_addr, m_as_, m_rw, m_wr_data,
    input  m_grnt_, m_rd_data, m_rdy_
  );

endinterface

// File: rtl/dma_ctrl_bus_master.sv
// Bus-master half of the DMA: transfer FSM, SRC/DST/COUNT counters and data buffer.
// One read then one write per word; the request is dropped for one cycle between words.
module dma_ctrl_bus_master
  import dma_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  dma_ctrl_if.master             mif,
  input  logic                   start,
  input  logic                   ld_src,
  input  logic                   ld_dst,
  input  logic                   ld_cnt,
  input  logic [WORD_ADDR_W-1:0] ld_addr,
  input  logic [CNT_W-1:0]       ld_count,
  output logic                   busy,
  output logic                   fin,
  output logic [WORD_ADDR_W-1:0] src,
  output logic [WORD_ADDR_W-1:0] dst,
  output logic [CNT_W-1:0]       cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 16'd1;

  dma_state_e             state_q, state_d;
  logic [WORD_ADDR_W-1:0] src_q, src_d;
  logic [WORD_ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_DATA_W-1:0] buf_q, buf_d;
  logic [WORD_ADDR_W-1:0] m_addr_q, m_addr_d;
  logic                   m_req_q, m_req_d;
  logic                   m_as_q, m_as_d;
  logic                   m_rw_q, m_rw_d;

  // Next-state and next-output logic; bus outputs are computed for the state being entered.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    m_addr_d = m_addr_q;
    m_req_d  = m_req_q;
    m_as_d   = m_as_q;
    m_rw_d   = m_rw_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_src) src_d = ld_addr; else src_d = src_q;
        if (ld_dst) dst_d = ld_addr; else dst_d = dst_q;
        if (ld_cnt) cnt_d = ld_count; else cnt_d = cnt_q;
        if (start) begin
          state_d = ST_REQ;
          m_req_d = ENABLE_;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mif.m_grnt_ == ENABLE_) begin
          state_d  = ST_RD_AS;
          m_as_d   = ENABLE_;
          m_rw_d   = READ;
          m_addr_d = src_q;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RD_AS: begin
        state_d = ST_RD_WAIT;
        m_as_d  = DISABLE_;
      end
      ST_RD_WAIT: begin
        if (mif.m_rdy_ == ENABLE_) begin
          state_d  = ST_WR_AS;
          buf_d    = mif.m_rd_data;
          m_as_d   = ENABLE_;
          m_rw_d   = WRITE;
          m_addr_d = dst_q;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_AS: begin
        state_d = ST_WR_WAIT;
        m_as_d  = DISABLE_;
        m_rw_d  = READ;
      end
      ST_WR_WAIT: begin
        if (mif.m_rdy_ == ENABLE_) begin
          state_d = ST_NEXT;
          m_req_d = DISABLE_;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_NEXT: begin
        src_d = word_inc(src_q);
        dst_d = word_inc(dst_q);
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
          m_req_d = ENABLE_;
        end
      end
      default: begin
        state_d = ST_IDLE;
        m_req_d = DISABLE_;
        m_as_d  = DISABLE_;
        m_rw_d  = READ;
      end
    endcase
  end

  // State, counters, buffer and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      src_q    <= 30'd0;
      dst_q    <= 30'd0;
      cnt_q    <= 16'd0;
      buf_q    <= 32'd0;
      m_addr_q <= 30'd0;
      m_req_q  <= DISABLE_;
      m_as_q   <= DISABLE_;
      m_rw_q   <= READ;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      m_addr_q <= m_addr_d;
      m_req_q  <= m_req_d;
      m_as_q   <= m_as_d;
      m_rw_q   <= m_rw_d;
    end
  end

  assign mif.m_req_    = m_req_q;
  assign mif.m_as_     = m_as_q;
  assign mif.m_rw      = m_rw_q;
  assign mif.m_addr    = m_addr_q;
  assign mif.m_wr_data = buf_q;

  assign busy = (state_q != ST_IDLE);
  assign fin  = (state_q == ST_NEXT) && (cnt_q == CNT_ONE);
  assign src  = src_q;
  assign dst  = dst_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/dma_ctrl.sv
// DMA top: CPU-visible register file (CTRL/SRC/DST/COUNT), slave response and done interrupt.
// The copy engine itself lives in dma_ctrl_bus_master.
module dma_ctrl
  import dma_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  dma_ctrl_if.slave   sif,
  dma_ctrl_if.master  mif,
  output logic        irq
);

  logic                   busy_s;
  logic                   fin_s;
  logic [WORD_ADDR_W-1:0] src_s;
  logic [WORD_ADDR_W-1:0] dst_s;
  logic [CNT_W-1:0]       cnt_s;
  logic                   sel_s;
  logic                   wr_s;
  logic                   start_s;
  logic                   ld_src_s;
  logic                   ld_dst_s;
  logic                   ld_cnt_s;

  logic                   done_q, done_d;
  logic                   ie_q, ie_d;
  logic                   irq_q, irq_d;
  logic                   rdy_q, rdy_d;
  logic [WORD_DATA_W-1:0] rd_data_q, rd_data_d;

  dma_ctrl_bus_master u_bus_master (
    .clk      (clk),
    .reset    (reset),
    .mif      (mif),
    .start    (start_s),
    .ld_src   (ld_src_s),
    .ld_dst   (ld_dst_s),
    .ld_cnt   (ld_cnt_s),
    .ld_addr  (sif.wr_data[WORD_ADDR_W-1:0]),
    .ld_count (sif.wr_data[CNT_W-1:0]),
    .busy     (busy_s),
    .fin      (fin_s),
    .src      (src_s),
    .dst      (dst_s),
    .cnt      (cnt_s)
  );

  // Register decode, readback mux and control-bit update; an engine DONE beats a CPU clear.
  always_comb begin
    sel_s     = (sif.cs_ == ENABLE_) && (sif.as_ == ENABLE_);
    wr_s      = sel_s && (sif.rw == WRITE);
    start_s   = 1'b0;
    ld_src_s  = 1'b0;
    ld_dst_s  = 1'b0;
    ld_cnt_s  = 1'b0;
    done_d    = done_q;
    ie_d      = ie_q;
    rdy_d     = sel_s ? ENABLE_ : DISABLE_;
    rd_data_d = 32'd0;
    if (sel_s && (sif.rw == READ)) begin
      case (dma_reg_e'(sif.addr))
        REG_CTRL:  rd_data_d = {29'd0, ie_q, done_q, busy_s};
        REG_SRC:   rd_data_d = {2'b00, src_s};
        REG_DST:   rd_data_d = {2'b00, dst_s};
        REG_COUNT: rd_data_d = {16'd0, cnt_s};
        default:   rd_data_d = 32'd0;
      endcase
    end else begin
      rd_data_d = 32'd0;
    end
    if (wr_s) begin
      case (dma_reg_e'(sif.addr))
        REG_CTRL: begin
          ie_d = sif.wr_data[CTRL_IE];
          if (!sif.wr_data[CTRL_DONE]) done_d = 1'b0; else done_d = done_q;
          if (!busy_s && sif.wr_data[CTRL_BUSY]) begin
            if (cnt_s == 16'd0) done_d = 1'b1; else start_s = 1'b1;
          end else begin
            start_s = 1'b0;
          end
        end
        REG_SRC:   ld_src_s = !busy_s;
        REG_DST:   ld_dst_s = !busy_s;
        REG_COUNT: ld_cnt_s = !busy_s;
        default:   start_s  = 1'b0;
      endcase
    end else begin
      start_s = 1'b0;
    end
    if (fin_s) done_d = 1'b1; else done_d = done_d;
    irq_d = done_d & ie_d;
  end

  // Control bits and registered slave/interrupt outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
      rdy_q     <= DISABLE_;
      rd_data_q <= 32'd0;
    end else begin
      done_q    <= done_d;
      ie_q      <= ie_d;
      irq_q     <= irq_d;
      rdy_q     <= rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign sif.rdy_    = rdy_q;
  assign sif.rd_data = rd_data_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: memory/arbiter model on the master port, scoreboard of expected bus ops.
module tb_dma_ctrl;
  import dma_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic irq;

  dma_ctrl_if bus();

  dma_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .sif   (bus),
    .mif   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [29:0] a;
    logic [31:0] d;
  } op_t;

  int          n_vec = 0;
  int          n_err = 0;
  op_t         exp_q[$];
  logic [31:0] mem [bit [29:0]];
  int          rsp_lat = 1;
  bit          gnt_en = 1'b1;
  int          req_seen = 0;
  int          as_seen = 0;
  int          wr_as_cnt = 0;
  logic [29:0] m_src;
  logic [29:0] m_dst;
  logic [15:0] m_cnt;

  function automatic logic [31:0] pattern(input logic [29:0] a);
    return {2'b00, a} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return pattern(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory slave + arbiter on the master port, and per-cycle output checks.
  initial begin : monitor
    int          pend;
    logic        p_rw;
    logic [29:0] p_a;
    op_t         e;
    pend = 0;
    p_rw = READ;
    p_a  = 30'd0;
    bus.m_grnt_    = 1'b1;
    bus.m_rdy_     = 1'b1;
    bus.m_rd_data  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        pend = 0;
      end else begin
        check("rdy_", 32'(bus.rdy_), (bus.cs_ == 1'b0 && bus.as_ == 1'b0) ? 32'd0 : 32'd1);
        if (!(bus.cs_ == 1'b0 && bus.as_ == 1'b0 && bus.rw == READ))
          check("rd_data_idle", bus.rd_data, 32'd0);
        if (bus.m_req_ == 1'b0) req_seen++;
        if (bus.m_as_ == 1'b0) begin
          as_seen++;
          check("as_with_grant", 32'(bus.m_grnt_), 32'd0);
          check("op_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("op_rw", 32'(bus.m_rw), 32'(e.rw));
            check("op_addr", 32'(bus.m_addr), 32'(e.a));
            if (e.rw == WRITE) check("op_wdata", bus.m_wr_data, e.d);
          end
          if (bus.m_rw == WRITE) begin
            mem[bus.m_addr] = bus.m_wr_data;
            wr_as_cnt++;
          end
          p_rw = bus.m_rw;
          p_a  = bus.m_addr;
          pend = rsp_lat + 1;
        end
      end
      @(negedge clk);
      bus.m_rdy_    = 1'b1;
      bus.m_rd_data = 32'd0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !reset) begin
          bus.m_rdy_ = 1'b0;
          if (p_rw == READ) bus.m_rd_data = mem_rd(p_a);
        end
      end
      bus.m_grnt_ = (bus.m_req_ == 1'b0 && gnt_en) ? 1'b0 : 1'b1;
    end
  end

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = WRITE; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs_ = 1'b1; bus.as_ = 1'b1; bus.rw = READ; bus.wr_data = 32'd0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    bus.cs_ = 1'b0; bus.as_ = 1'b0; bus.rw = READ; bus.addr = a;
    @(negedge clk);
    d = bus.rd_data;
    bus.cs_ = 1'b1; bus.as_ = 1'b1;
  endtask

  task automatic setup(input logic [29:0] s, input logic [29:0] d, input logic [15:0] c);
    reg_wr(2'd1, {2'b00, s}); m_src = s;
    reg_wr(2'd2, {2'b00, d}); m_dst = d;
    reg_wr(2'd3, {16'd0, c}); m_cnt = c;
  endtask

  // Expected bus traffic: for each word, read SRC+i then write DST+i with that word.
  task automatic start_xfer();
    for (int i = 0; i < int'(m_cnt); i++) begin
      op_t o;
      o.rw = READ;  o.a = m_src + 30'(i); o.d = 32'd0;
      exp_q.push_back(o);
      o.rw = WRITE; o.d = mem_rd(m_src + 30'(i)); o.a = m_dst + 30'(i);
      exp_q.push_back(o);
    end
    reg_wr(2'd0, 32'h5);
  endtask

  task automatic wait_irq(input string name, input int budget);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_irq"}, 32'(irq), 32'd1);
    check({name, "_ops_left"}, 32'(exp_q.size()), 32'd0);
    m_src = m_src + 30'(m_cnt);
    m_dst = m_dst + 30'(m_cnt);
    m_cnt = 16'd0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rd_data"}, bus.rd_data, 32'd0);
    check({tag, "_rdy_"}, 32'(bus.rdy_), 32'd1);
    check({tag, "_m_req_"}, 32'(bus.m_req_), 32'd1);
    check({tag, "_m_as_"}, 32'(bus.m_as_), 32'd1);
    check({tag, "_m_rw"}, 32'(bus.m_rw), 32'(READ));
    check({tag, "_m_addr"}, 32'(bus.m_addr), 32'd0);
    check({tag, "_m_wr_data"}, bus.m_wr_data, 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin : stim
    logic [31:0] d;
    int          r0;
    int          n;
    bus.cs_ = 1'b1; bus.as_ = 1'b1; bus.rw = READ; bus.addr = 2'd0; bus.wr_data = 32'd0;
    m_src = 30'd0; m_dst = 30'd0; m_cnt = 16'd0;
    reset = 1'b1;
    #1;
    check_reset_outs("t1_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // T1: all registers read zero after reset
    for (int a = 0; a < 4; a++) begin
      reg_rd(2'(a), d);
      check($sformatf("t1_reg%0d", a), d, 32'd0);
    end
    check("t1_irq", 32'(irq), 32'd0);

    // T2: three-word copy 0x100.. -> 0x200..
    rsp_lat = 1;
    setup(30'h100, 30'h200, 16'd3);
    start_xfer();
    wait_irq("t2", 300);
    reg_rd(2'd0, d); check("t2_ctrl", d, 32'h6);
    reg_rd(2'd3, d); check("t2_count", d, 32'd0);
    reg_rd(2'd1, d); check("t2_src", d, 32'h103);
    check("t2_src_model", d, {2'b00, m_src});
    reg_rd(2'd2, d); check("t2_dst", d, 32'h203);
    check("t2_mem0_lit", mem_rd(30'h200), 32'hA5A5_0100);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_mem%0d", i), mem_rd(30'h200 + 30'(i)), pattern(30'h100 + 30'(i)));
    reg_wr(2'd0, 32'h4);
    check("t2_irq_cleared", 32'(irq), 32'd0);

    // T3: START with COUNT=0 completes without bus activity
    r0 = req_seen;
    reg_wr(2'd0, 32'h5);
    check("t3_irq_next_cycle", 32'(irq), 32'd1);
    repeat (10) @(negedge clk);
    check("t3_no_req", 32'(req_seen - r0), 32'd0);
    reg_rd(2'd0, d); check("t3_ctrl", d, 32'h6);
    reg_wr(2'd0, 32'h4);

    // T4: grant withheld for 20 cycles
    gnt_en = 1'b0;
    rsp_lat = 2;
    setup(30'h300, 30'h400, 16'd2);
    r0 = as_seen;
    start_xfer();
    repeat (20) @(negedge clk);
    check("t4_no_as", 32'(as_seen - r0), 32'd0);
    check("t4_req_held", 32'(bus.m_req_), 32'd0);
    reg_rd(2'd0, d); check("t4_ctrl_busy", d, 32'h5);
    gnt_en = 1'b1;
    wait_irq("t4", 300);
    check("t4_mem1", mem_rd(30'h401), pattern(30'h301));
    reg_wr(2'd0, 32'h4);

    // T5: source address wraps; DST write while busy is ignored
    rsp_lat = 1;
    setup(30'h3FFF_FFFF, 30'h500, 16'd2);
    start_xfer();
    reg_wr(2'd2, 32'h999);
    wait_irq("t5", 300);
    reg_rd(2'd2, d); check("t5_dst", d, 32'h502);
    reg_rd(2'd1, d); check("t5_src_wrap", d, 32'h1);
    check("t5_mem1", mem_rd(30'h501), pattern(30'h0));
    reg_wr(2'd0, 32'h4);

    // T6: reset while waiting for a write acknowledge, then a fresh transfer
    rsp_lat = 3;
    setup(30'h600, 30'h700, 16'd4);
    r0 = wr_as_cnt;
    start_xfer();
    n = 0;
    while (wr_as_cnt == r0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_write", 32'(wr_as_cnt > r0), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outs("t6_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_src = 30'd0; m_dst = 30'd0; m_cnt = 16'd0;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      reg_rd(2'(a), d);
      check($sformatf("t6_reg%0d", a), d, 32'd0);
    end
    rsp_lat = 1;
    setup(30'h800, 30'h900, 16'd2);
    start_xfer();
    wait_irq("t6_fresh", 300);
    check("t6_mem0", mem_rd(30'h900), pattern(30'h800));
    check("t6_mem1", mem_rd(30'h901), pattern(30'h801));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
